// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin arbiter sharing one sprite ROM
// among NREQ pixel requesters, with a tag pipe to route responses.
//
// Ports:
//   vga_clk, reset_n  clock, async active-low reset
//   req_valid/addr    per-requester read requests (slice i = req i)
//   req_ready         one-hot-or-zero grant (combinational)
//   rom_address/en    registered ROM read port
//   rom_q             ROM data, valid ROM_LAT cycles after rom_en
//   resp_valid/data   one-hot owner of rom_q, data gated to 0 when idle
//
// Option: define SPRITE_ARB_REQ0_PRIORITY_EN to give requester 0
// absolute priority; the rest then round-robin among themselves.
module sprite_rom_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 3,
  parameter int ROM_LAT = 1
) (
  input  logic                     vga_clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]        rom_address,
  output logic                     rom_en,
  input  logic [DATA_W-1:0]        rom_q,
  output logic [NREQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]        resp_data
);

  localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           win;
  logic           hs;
  logic [IDW-1:0] issue_id;

  logic [ROM_LAT-1:0] tag_v;
  logic [IDW-1:0]     tag_id [ROM_LAT];

  // Search starts just past the last winner; with the priority
  // option, requester 0 is excluded from the rotation and simply
  // overrides it.
  always_comb begin
    win    = 1'b0;
    win_id = '0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!win && req_valid[idx] &&
          !(PRIO0 && idx == '0)) begin
        win    = 1'b1;
        win_id = idx;
      end
    end
    if (PRIO0 && req_valid[0]) begin
      win    = 1'b1;
      win_id = '0;
    end
  end

  assign hs        = win && reset_n;
  assign req_ready = hs ? (ONE << win_id) : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant  <= IDW'(NREQ - 1);
      rom_address <= '0;
      rom_en      <= 1'b0;
      issue_id    <= '0;
    end else begin
      rom_en <= hs;
      if (hs) begin
        rom_address <= req_addr[win_id*ADDR_W +: ADDR_W];
        issue_id    <= win_id;
        if (!(PRIO0 && win_id == '0))
          last_grant <= win_id;
      end
    end
  end

  // Tag pipe tracks which requester owns each outstanding read.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      for (int i = 0; i < ROM_LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= rom_en;
      tag_id[0] <= issue_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign resp_valid = tag_v[ROM_LAT-1] ?
                      (ONE << tag_id[ROM_LAT-1]) : '0;
  assign resp_data  = tag_v[ROM_LAT-1] ? rom_q : '0;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed and random checks of the arbiter
// at ROM_LAT=1 and ROM_LAT=3 against a cycle-history model.
module tb_sprite_rom_arbiter;

  localparam int N  = 3;
  localparam int AW = 19;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid;
  logic [N*AW-1:0] addr;

  logic [N-1:0]  rdy1, rdy3, rv1, rv3;
  logic [AW-1:0] ra1, ra3;
  logic          en1, en3;
  logic [DW-1:0] q1, q3, rd1, rd3;

  logic [AW-1:0] p1;
  logic [AW-1:0] p3 [3];

  bit run = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sprite_rom_arbiter u1 (
    .vga_clk(clk), .reset_n(rst_n),
    .req_valid(valid), .req_addr(addr),
    .req_ready(rdy1), .rom_address(ra1), .rom_en(en1),
    .rom_q(q1), .resp_valid(rv1), .resp_data(rd1)
  );

  sprite_rom_arbiter #(.ROM_LAT(3)) u3 (
    .vga_clk(clk), .reset_n(rst_n),
    .req_valid(valid), .req_addr(addr),
    .req_ready(rdy3), .rom_address(ra3), .rom_en(en3),
    .rom_q(q3), .resp_valid(rv3), .resp_data(rd3)
  );

  function automatic logic [DW-1:0] romf(logic [AW-1:0] a);
    return a[2:0] ^ a[5:3] ^ a[18:16] ^ 3'd5;
  endfunction

  // Behavioural ROMs with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    p1    <= ra1;
    p3[0] <= ra3;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign q1 = romf(p1);
  assign q3 = romf(p3[2]);

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Spec rule: start after last winner, first valid wins.
  function automatic int arb(logic [N-1:0] v, int lg);
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
    if (v[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (lg + k) % N;
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(int i);
    return (i < 0) ? '0 : N'(1 << i);
  endfunction

  // Model state: hv[j] = handshake j+1 cycles ago.
  int            m_lg = N - 1;
  logic [AW-1:0] m_addr = '0;
  bit            hv [4];
  int            hid [4];
  logic [AW-1:0] haddr [4];

  always @(negedge clk) begin
    if (run) begin
      if (!rst_n) begin
        check("rst_ready1", rdy1, 0);
        check("rst_ready3", rdy3, 0);
        check("rst_en1", en1, 0);
        check("rst_addr1", ra1, 0);
        check("rst_resp1", rv1, 0);
        check("rst_resp3", rv3, 0);
        check("rst_data1", rd1, 0);
        m_lg   = N - 1;
        m_addr = '0;
        for (int j = 0; j < 4; j++) hv[j] = 1'b0;
      end else begin
        int g;
        g = arb(valid, m_lg);
        check("ready1", rdy1, oh(g));
        check("ready3", rdy3, oh(g));
        check("rom_en1", en1, hv[0]);
        check("rom_en3", en3, hv[0]);
        check("rom_addr1", ra1, m_addr);
        check("rom_addr3", ra3, m_addr);
        check("resp1", rv1, hv[1] ? oh(hid[1]) : '0);
        check("data1", rd1, hv[1] ? romf(haddr[1]) : '0);
        check("resp3", rv3, hv[3] ? oh(hid[3]) : '0);
        check("data3", rd3, hv[3] ? romf(haddr[3]) : '0);
        for (int j = 3; j > 0; j--) begin
          hv[j]    = hv[j-1];
          hid[j]   = hid[j-1];
          haddr[j] = haddr[j-1];
        end
        hv[0] = (g >= 0);
        if (g >= 0) begin
          hid[0]   = g;
          haddr[0] = addr[g*AW +: AW];
          m_addr   = haddr[0];
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
          if (g != 0) m_lg = g;
`else
          m_lg = g;
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(logic [N-1:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  int exp_seq [6];
  int gi;

  initial begin
    rst_n = 1'b0;
    valid = '0;
    addr  = '0;
    run   = 1'b1;
    repeat (3) @(negedge clk);
    check("lit_rst_en", en1, 0);
    check("lit_rst_resp", rv1, 0);

    // Single request from background.
    step();
    rst_n = 1'b1;
    valid = 3'b001;
    addr[0 +: AW] = 19'd1234;
    @(negedge clk);
    check("lit_single_ready", rdy1, 3'b001);
    step();
    valid = '0;
    @(negedge clk);
    check("lit_single_en", en1, 1);
    check("lit_single_addr", ra1, 1234);
    step();
    @(negedge clk);
    check("lit_single_resp", rv1, 3'b001);
    check("lit_single_data", rd1, romf(19'd1234));
    repeat (2) @(negedge clk);
    check("lit_single_resp3", rv3, 3'b001);

    // Idle after a read of address 77.
    step();
    valid = 3'b010;
    addr[AW +: AW] = 19'd77;
    step();
    valid = '0;
    repeat (10) step();
    @(negedge clk);
    check("lit_idle_en", en1, 0);
    check("lit_idle_addr", ra1, 77);
    check("lit_idle_resp", rv1, 0);

    // Mid-operation reset after two handshakes.
    step();
    valid = 3'b110;
    step();
    step();
    valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("lit_rst_drop3", rv3, 0);
    end

    // All requesters continuously valid right after reset.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    valid = 3'b111;
    addr  = {19'd30, 19'd20, 19'd10};
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
    exp_seq = '{0, 0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2};
`endif
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gi = idx_of(rdy1);
      check("lit_rr_seq", gi, exp_seq[i]);
      step();
    end
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
    valid = 3'b110;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      gi = idx_of(rdy1);
      check("lit_prio_alt", gi, (i % 2 == 0) ? 1 : 2);
      step();
    end
`endif

    // Random traffic with occasional resets.
    for (int c = 0; c < 600; c++) begin
      step();
      rst_n = ($urandom_range(0, 59) != 0);
      valid = N'($urandom);
      for (int i = 0; i < N; i++)
        addr[i*AW +: AW] = AW'($urandom);
    end
    step();
    valid = '0;
    rst_n = 1'b1;
    repeat (6) step();
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of requesters (0 = background, 1 = paddles, 2 = ball); legal range 2..8.
REQ-002 Parameter ADDR_W, default 19, ROM address width.
REQ-003 Parameter DATA_W, default 3, ROM palette-index width.
REQ-004 Parameter ROM_LAT, default 1, cycles from rom_address/rom_en registered to rom_q valid; legal range 1..4.
REQ-005 vga_clk  input  1  sole clock, all state on posedge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  NREQ  per-requester read request.
REQ-008 req_addr  input  NREQ*ADDR_W  per-requester address, slice i = requester i.
REQ-009 req_ready  output  NREQ  one-hot-or-zero grant, combinational from req_valid and state.
REQ-010 rom_address  output  ADDR_W  registered address to the shared sprite ROM.
REQ-011 rom_en  output  1  registered, high when rom_address carries a granted read.
REQ-012 rom_q  input  DATA_W  ROM read data.
REQ-013 resp_valid  output  NREQ  one-hot-or-zero, marks the requester owning rom_q this cycle.
REQ-014 resp_data  output  DATA_W  equals rom_q whenever any resp_valid bit is high, else 0.

Function
REQ-015 At most one requester SHALL be granted per cycle; a handshake occurs when req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready[i] SHALL never be high while req_valid[i] is low; with any req_valid high, exactly one ready bit SHALL be high.
REQ-017 Arbitration SHALL be round-robin: search begins at last_grant+1 mod NREQ; the first valid requester wins.
REQ-018 last_grant SHALL update to the winner on each handshake and hold otherwise.
REQ-019 On a handshake in cycle t, rom_address SHALL hold the winner's req_addr and rom_en SHALL be 1 in cycle t+1.
REQ-020 With no handshake, rom_en SHALL be 0 in the next cycle and rom_address SHALL hold its previous value.
REQ-021 A tag pipeline of depth ROM_LAT SHALL carry {valid, id} alongside each read.
REQ-022 resp_valid[id] SHALL be 1 in cycle t+1+ROM_LAT for a handshake in cycle t.
REQ-023 Back-to-back handshakes SHALL be accepted every cycle, giving full throughput of one read per cycle with responses in grant order.
REQ-024 No backpressure on responses: requesters SHALL accept resp_valid unconditionally.
REQ-025 A requester deasserting req_valid before handshake SHALL lose no state; the pointer SHALL not move.
REQ-026 Pointer wrap: after a grant to NREQ-1, search SHALL start at requester 0.

Reset
REQ-027 While reset_n is low: req_ready 0, rom_en 0, rom_address 0, resp_valid 0, resp_data 0, tag pipeline cleared, last_grant = NREQ-1.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight tags; no resp_valid SHALL appear for reads issued before reset.
REQ-029 In the first cycle after reset release, requester 0 SHALL win any contention.

Configuration
REQ-030 Macro SPRITE_ARB_REQ0_PRIORITY_EN: when defined, requester 0 SHALL win whenever req_valid[0] is high, other requesters arbitrate round-robin among themselves, and grants to requester 0 SHALL not move last_grant.
REQ-031 When SPRITE_ARB_REQ0_PRIORITY_EN is undefined, all NREQ requesters SHALL share pure round-robin per REQ-017.

Verification
REQ-032 Single request: req_valid=3'b001, addr0=19'd1234, cycle 5 -> req_ready=3'b001 cycle 5, rom_en=1 and rom_address=1234 cycle 6, resp_valid=3'b001 with resp_data=rom_q cycle 7.
REQ-033 All three continuously valid, macro off -> grant sequence 0,1,2,0,1,2; responses in same order, one per cycle, no gaps.
REQ-034 Same stimulus, macro on -> grants 0,0,0...; after req_valid[0] drops, grants alternate 1,2,1,2.
REQ-035 Reset asserted one cycle after two handshakes -> resp_valid stays 0 throughout and after release; last_grant returns to 2.
REQ-036 ROM_LAT=3, alternate requests 1 and 2 with addresses 100 and 200 -> resp_valid 3'b010 then 3'b100 exactly 4 cycles after each handshake, data matching ROM contents.
REQ-037 Idle (req_valid=0) for 10 cycles after a read of address 77 -> rom_en=0, rom_address stays 77, resp_valid=0.
